// File: rtl/poco_mem_resp.sv
// Single-port word memory answering req/ack transactions after LAT wait cycles.
// Flags out-of-range addresses and counts error-free completed accesses.
module poco_mem_resp #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [15:0]       acc_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W:0] DEPTH_LIM = (DATA_W + 1)'(DEPTH);
    localparam logic [3:0] LAT_C = 4'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic load;

    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              t_we;
    logic [DATA_W-1:0] t_addr;
    logic [DATA_W-1:0] t_wdata;
    logic              t_in_range;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rdata_d;
    logic              commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    load = 1'b1;
                    if (LAT == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_C;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LAT=0 the response is formed on the same edge that latches the
    // request, so the response data path looks through to the live inputs.
    always_comb begin
        t_we       = load ? we    : we_q;
        t_addr     = load ? addr  : addr_q;
        t_wdata    = load ? wdata : wdata_q;
        t_in_range = ({1'b0, t_addr} < DEPTH_LIM);
        rd_word    = mem[t_addr[AW-1:0]];
        rdata_d    = '0;
        if (t_in_range) rdata_d = t_we ? t_wdata : rd_word;
    end

    assign commit = (state_q == RESP) && !err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            acc_cnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            busy <= (state_d != IDLE);
            ack  <= (state_d == RESP);
            err  <= (state_d == RESP) && !t_in_range;
            if (state_d == RESP) rdata <= rdata_d;
            if (commit) acc_cnt <= acc_cnt + 16'd1;
        end
    end

    // Index truncation is safe: the range check blocks any out-of-range write.
    always_ff @(posedge clk) begin
        if (!rst && commit && we_q) mem[addr_q[AW-1:0]] <= wdata_q;
    end

endmodule

// File: tb/tb_poco_mem_resp.sv
// Directed bench for poco_mem_resp: LAT=2 instance driven from a vector table
// plus hand sequences, and a LAT=0 instance for back-to-back throughput.
module tb_poco_mem_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic [15:0] rdata;
    logic        ack, err, busy;
    logic [15:0] acc_cnt;

    logic        req0, we0;
    logic [15:0] addr0, wdata0;
    logic [15:0] rdata0;
    logic        ack0, err0, busy0;
    logic [15:0] acc_cnt0;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    poco_mem_resp #(.DATA_W(16), .DEPTH(256), .LAT(LAT)) u2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy), .acc_cnt(acc_cnt)
    );

    poco_mem_resp #(.DATA_W(16), .DEPTH(256), .LAT(0)) u0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0), .acc_cnt(acc_cnt0)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge with the FSM in IDLE.
    task automatic do_txn(input vec_t v);
        int n;
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
        @(posedge clk); #1;
        req = 1'b0;
        n = 1;
        while (!ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, LAT + 1);
        chk("ack", ack, 1);
        chk("busy_resp", busy, 1);
        chk("rdata", rdata, v.exp_rdata);
        chk("err", err, v.exp_err);
        if (!v.exp_err) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk); #1;
        chk("ack_pulse", ack, 0);
        chk("acc_cnt", acc_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_n, ack_n, seen;
        logic [15:0] last_rd;

        vecs[0] = '{1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b0};
        vecs[1] = '{1'b1, 16'h0100, 16'hAAAA, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 16'h00FF, 16'h1357, 16'h1357, 1'b0};
        vecs[5] = '{1'b0, 16'h00FF, 16'h0000, 16'h1357, 1'b0};
        vecs[6] = '{1'b1, 16'h0007, 16'h7777, 16'h7777, 1'b0};
        vecs[7] = '{1'b0, 16'h0007, 16'h0000, 16'h7777, 1'b0};

        u2.mem[3] = 16'h1234;
        u2.mem[0] = 16'h0F0F;
        u0.mem[1] = 16'hA5A5;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = '0;
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_acc", acc_cnt, 0);

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Write then read with req held: 6 busy cycles out of 8.
        req = 1'b1; we = 1'b1; addr = 16'h0005; wdata = 16'hBEEF;
        busy_n = 0; ack_n = 0; last_rd = '0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (e == 0) we = 1'b0;
            if (e == 6) req = 1'b0;
            if (busy) busy_n++;
            if (ack) begin
                ack_n++;
                last_rd = rdata;
            end
        end
        exp_cnt = exp_cnt + 16'd2;
        chk("b2b_busy", busy_n, 6);
        chk("b2b_acks", ack_n, 2);
        chk("b2b_raw", last_rd, 16'hBEEF);
        chk("b2b_acc", acc_cnt, exp_cnt);

        // Reset during WAIT aborts the write.
        req = 1'b1; we = 1'b1; addr = 16'h0007; wdata = 16'h5555;
        @(posedge clk); #1;
        req = 1'b0;
        chk("abort_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
        chk("abort_idle", busy, 0);
        chk("abort_acc", acc_cnt, exp_cnt);
        seen = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (ack) seen++;
        end
        chk("abort_noack", seen, 0);

        // Reset coinciding with the RESP cycle also blocks the write.
        req = 1'b1; we = 1'b1; addr = 16'h0007; wdata = 16'h6666;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("resp_rst_ack", ack, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("resp_rst_acc", acc_cnt, 0);
        chk("resp_rst_ackclr", ack, 0);
        do_txn(vecs[7]);

        // Counter wraparound.
        force u2.acc_cnt = 16'hFFFF;
        #1;
        release u2.acc_cnt;
        exp_cnt = 16'hFFFF;
        do_txn('{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0});
        chk("wrap_zero", acc_cnt, 16'h0000);

        // LAT=0: reads with req held give an ack every other cycle.
        req0 = 1'b1; addr0 = 16'h0001;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            chk("lat0_ack", ack0, (e % 2 == 0) ? 1 : 0);
            if (ack0) chk("lat0_rdata", rdata0, 16'hA5A5);
        end
        req0 = 1'b0;
        chk("lat0_acc", acc_cnt0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
